ram_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data RAM (10-bit word address, 32-bit data, synchronous write, registered read). Shares the RAM between the instruction-fetch requester (read-only) and the load/store requester (read/write). Each access is granted round-robin, driven onto the RAM for one cycle, and completed with a one-cycle READY pulse to the owner.

---
 rtl/ram_arbiter.sv | 92 +++++++++
 tb/tb_ram_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port RAM between fetch (read-only) and load/store ports
// Ports:
//   CLK, RESET                   clock and asynchronous active-high reset
//   I_REQ, I_ADDRESS             fetch request and address
//   I_READY, I_DATA              fetch completion pulse and read data
//   D_REQ, D_WRITE_ENABLE,
//   D_ADDRESS, D_DATA_IN         load/store request, direction, address, store data
//   D_READY, D_DATA              load/store completion pulse and load data
//   RAM_ADDRESS, RAM_DATA_IN,
//   RAM_WRITE_ENABLE             drive to the RAM
//   RAM_DATA_OUT                 registered read data from the RAM
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_REQ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic                  I_READY,
    output logic [DATA_WIDTH-1:0] I_DATA,
    input  logic                  D_REQ,
    input  logic                  D_WRITE_ENABLE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_DATA_IN,
    output logic                  D_READY,
    output logic [DATA_WIDTH-1:0] D_DATA,
    output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
    output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
    output logic                  RAM_WRITE_ENABLE,
    input  logic [DATA_WIDTH-1:0] RAM_DATA_OUT
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                state;
    logic                  last_d;
    logic                  owner_d;
    logic                  lat_we;
    logic                  grant_d;
    logic [DATA_WIDTH-1:0] i_hold;
    logic [DATA_WIDTH-1:0] d_hold;

    // RAM_ADDRESS/RAM_DATA_IN double as the latched request registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state            <= IDLE;
            last_d           <= 1'b1;
            owner_d          <= 1'b0;
            lat_we           <= 1'b0;
            RAM_ADDRESS      <= '0;
            RAM_DATA_IN      <= '0;
            RAM_WRITE_ENABLE <= 1'b0;
            I_READY          <= 1'b0;
            D_READY          <= 1'b0;
            i_hold           <= '0;
            d_hold           <= '0;
        end else begin
            case (state)
                IDLE: if (I_REQ || D_REQ) begin
                    owner_d          <= grant_d;
                    last_d           <= grant_d;
                    RAM_ADDRESS      <= grant_d ? D_ADDRESS : I_ADDRESS;
                    RAM_DATA_IN      <= grant_d ? D_DATA_IN : RAM_DATA_IN;
                    lat_we           <= grant_d && D_WRITE_ENABLE;
                    RAM_WRITE_ENABLE <= grant_d && D_WRITE_ENABLE;
                    state            <= ACCESS;
                end
                ACCESS: begin
                    RAM_WRITE_ENABLE <= 1'b0;
                    I_READY          <= !owner_d;
                    D_READY          <= owner_d;
                    state            <= RESPOND;
                end
                RESPOND: begin
                    I_READY <= 1'b0;
                    D_READY <= 1'b0;
                    if (I_READY) i_hold <= RAM_DATA_OUT;
                    if (D_READY && !lat_we) d_hold <= RAM_DATA_OUT;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a lone D request wins; on a tie D wins only if fetch went last
    always_comb begin
        grant_d = D_REQ && (!I_REQ || !last_d);
        I_DATA  = I_READY ? RAM_DATA_OUT : i_hold;
        D_DATA  = (D_READY && !lat_we) ? RAM_DATA_OUT : d_hold;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table, hand sequences and randomized model check for ram_arbiter
module tb_ram_arbiter;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        I_REQ = 1'b0;
    logic [9:0]  I_ADDRESS = 10'd0;
    logic        I_READY;
    logic [31:0] I_DATA;
    logic        D_REQ = 1'b0;
    logic        D_WRITE_ENABLE = 1'b0;
    logic [9:0]  D_ADDRESS = 10'd0;
    logic [31:0] D_DATA_IN = 32'd0;
    logic        D_READY;
    logic [31:0] D_DATA;
    logic [9:0]  RAM_ADDRESS;
    logic [31:0] RAM_DATA_IN;
    logic        RAM_WRITE_ENABLE;
    logic [31:0] RAM_DATA_OUT = 32'd0;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [1024] = '{default: 32'h0};
    logic [31:0] mm  [1024] = '{default: 32'h0};

    ram_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_REQ(I_REQ), .I_ADDRESS(I_ADDRESS), .I_READY(I_READY), .I_DATA(I_DATA),
        .D_REQ(D_REQ), .D_WRITE_ENABLE(D_WRITE_ENABLE), .D_ADDRESS(D_ADDRESS),
        .D_DATA_IN(D_DATA_IN), .D_READY(D_READY), .D_DATA(D_DATA),
        .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATA_IN(RAM_DATA_IN),
        .RAM_WRITE_ENABLE(RAM_WRITE_ENABLE), .RAM_DATA_OUT(RAM_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RAM_WRITE_ENABLE) mem[RAM_ADDRESS] <= RAM_DATA_IN;
        RAM_DATA_OUT <= mem[RAM_ADDRESS];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        rst, ir;
        logic [9:0]  ia;
        logic        dr, dw;
        logic [9:0]  da;
        logic [31:0] dd;
        logic        eir, edr, ewe;
        logic [9:0]  ea;
        logic [31:0] eid, edd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic row(input logic rst, input logic ir, input logic [9:0] ia, input logic dr,
                       input logic dw, input logic [9:0] da, input logic [31:0] dd,
                       input logic eir, input logic edr, input logic ewe, input logic [9:0] ea,
                       input logic [31:0] eid, input logic [31:0] edd);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.eir = eir; v.edr = edr; v.ewe = ewe; v.ea = ea; v.eid = eid; v.edd = edd;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        I_REQ = 1'b0; D_REQ = 1'b0; D_WRITE_ENABLE = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // transaction-level reference: phase 0 free, 1 RAM access, 2 response
    int          ph;
    logic        own_d, last_d, m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_din, m_ih, m_dh;

    task automatic model_reset();
        ph = 0; own_d = 1'b0; last_d = 1'b1; m_we = 1'b0;
        m_addr = 10'd0; m_din = 32'd0; m_ih = 32'd0; m_dh = 32'd0;
    endtask

    task automatic model_step();
        if (ph == 0) begin
            if (I_REQ || D_REQ) begin
                own_d  = (D_REQ && !I_REQ) || (D_REQ && I_REQ && !last_d);
                last_d = own_d;
                m_addr = own_d ? D_ADDRESS : I_ADDRESS;
                if (own_d) m_din = D_DATA_IN;
                m_we   = own_d && D_WRITE_ENABLE;
                ph     = 1;
            end
        end else if (ph == 1) begin
            if (m_we) mm[m_addr] = m_din;
            ph = 2;
        end else begin
            if (!own_d) m_ih = mm[m_addr];
            else if (!m_we) m_dh = mm[m_addr];
            ph = 0;
        end
    endtask

    initial begin
        logic        eir, edr, ewe;
        logic [31:0] eid, edd;
        int          pulses;

        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd1, 32'd55, 1'b0, 1'b0, 1'b1, 10'd1, 32'd0,  32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd1, 32'd55, 1'b0, 1'b1, 1'b0, 10'd1, 32'd0,  32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd1, 32'd0,  32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd2, 32'd99, 1'b0, 1'b0, 1'b1, 10'd2, 32'd0,  32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 10'd2, 32'd99, 1'b0, 1'b1, 1'b0, 10'd2, 32'd0,  32'd0);
        row(1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd2, 32'd0,  32'd0);
        row(1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd1, 32'd0,  32'd0);
        row(1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0,  1'b1, 1'b0, 1'b0, 10'd1, 32'd55, 32'd0);
        row(1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd1, 32'd55, 32'd0);
        row(1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd2, 32'd55, 32'd0);
        row(1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 32'd0,  1'b1, 1'b0, 1'b0, 10'd2, 32'd99, 32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd2, 32'd99, 32'd0);
        row(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd0, 32'd0,  32'd0);
        row(1'b0, 1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'd0,  1'b0, 1'b0, 1'b0, 10'd1, 32'd0,  32'd0);
        row(1'b0, 1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'd0,  1'b1, 1'b0, 1'b0, 10'd1, 32'd55, 32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd2, 32'd0,  1'b0, 1'b0, 1'b0, 10'd1, 32'd55, 32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd2, 32'd0,  1'b0, 1'b0, 1'b0, 10'd2, 32'd55, 32'd0);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd2, 32'd0,  1'b0, 1'b1, 1'b0, 10'd2, 32'd55, 32'd99);
        row(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd2, 32'd55, 32'd99);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd1, 32'd0,  1'b0, 1'b0, 1'b0, 10'd1, 32'd55, 32'd99);
        row(1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 10'd2, 32'd0,  1'b0, 1'b1, 1'b0, 10'd1, 32'd55, 32'd55);
        row(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,  1'b0, 1'b0, 1'b0, 10'd1, 32'd55, 32'd55);

        #2;
        check("reset_async", {I_READY, D_READY, RAM_WRITE_ENABLE, RAM_ADDRESS, RAM_DATA_IN, I_DATA, D_DATA}, 128'd0);
        tick();
        RESET = 1'b0;

        foreach (vecs[k]) begin
            I_REQ = vecs[k].ir; I_ADDRESS = vecs[k].ia;
            D_REQ = vecs[k].dr; D_WRITE_ENABLE = vecs[k].dw;
            D_ADDRESS = vecs[k].da; D_DATA_IN = vecs[k].dd;
            RESET = vecs[k].rst;
            tick();
            check($sformatf("vec%0d", k),
                  {I_READY, D_READY, RAM_WRITE_ENABLE, RAM_ADDRESS, I_DATA, D_DATA},
                  {vecs[k].eir, vecs[k].edr, vecs[k].ewe, vecs[k].ea, vecs[k].eid, vecs[k].edd});
            if (k == 0) check("store_data_in", RAM_DATA_IN, 128'd55);
            RESET = 1'b0;
        end

        // both held: I first after reset, then strict alternation every 3 cycles
        do_reset();
        I_REQ = 1'b1; I_ADDRESS = 10'd1;
        D_REQ = 1'b1; D_WRITE_ENABLE = 1'b0; D_ADDRESS = 10'd2;
        pulses = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            pulses += int'(I_READY) + int'(D_READY);
            check($sformatf("alt_t%0d", t), {I_READY, D_READY},
                  {(t == 2 || t == 8) ? 1'b1 : 1'b0, (t == 5 || t == 11) ? 1'b1 : 1'b0});
        end
        check("alt_pulses", 128'(pulses), 128'd4);

        // store aborted by reset during ACCESS
        do_reset();
        D_REQ = 1'b1; D_WRITE_ENABLE = 1'b1; D_ADDRESS = 10'd3; D_DATA_IN = 32'hDEADBEEF;
        tick();
        check("abort_we_high", RAM_WRITE_ENABLE, 128'd1);
        #2 RESET = 1'b1;
        #1 check("abort_we_drop", {RAM_WRITE_ENABLE, D_READY}, 128'd0);
        tick();
        check("abort_no_ready", {D_READY, I_READY}, 128'd0);
        D_REQ = 1'b0; D_WRITE_ENABLE = 1'b0;
        RESET = 1'b0;
        I_REQ = 1'b1; I_ADDRESS = 10'd3;
        tick();
        tick();
        check("abort_read_ready", I_READY, 128'd1);
        tests++;
        if (I_DATA === 32'hDEADBEEF) begin
            fails++;
            $display("FAIL abort_read_data: got %0h required anything but deadbeef", I_DATA);
        end
        I_REQ = 1'b0;
        tick();

        // load aborted by reset during RESPOND
        D_REQ = 1'b1; D_WRITE_ENABLE = 1'b0; D_ADDRESS = 10'd1;
        tick();
        tick();
        check("respond_ready", {D_READY, D_DATA}, {1'b1, 32'd55});
        #2 RESET = 1'b1;
        #1 check("respond_abort", {D_READY, D_DATA}, 128'd0);
        D_REQ = 1'b0;
        tick();
        RESET = 1'b0;

        // randomized traffic against the reference model, addresses 16..31
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            model_step();
            #1;
            eir = (ph == 2) && !own_d;
            edr = (ph == 2) && own_d;
            ewe = (ph == 1) && m_we;
            eid = eir ? mm[m_addr] : m_ih;
            edd = (edr && !m_we) ? mm[m_addr] : m_dh;
            check($sformatf("rand_c%0d", c),
                  {I_READY, D_READY, RAM_WRITE_ENABLE, RAM_ADDRESS, I_DATA, D_DATA},
                  {eir, edr, ewe, m_addr, eid, edd});
            if (ewe) check($sformatf("rand_din_c%0d", c), RAM_DATA_IN, 128'(m_din));
            if (!I_REQ || I_READY) begin
                I_REQ = ($urandom_range(0, 3) != 0);
                I_ADDRESS = 10'(16 + $urandom_range(0, 15));
            end
            if (!D_REQ || D_READY) begin
                D_REQ = ($urandom_range(0, 3) != 0);
                D_WRITE_ENABLE = $urandom_range(0, 1) == 1;
                D_ADDRESS = 10'(16 + $urandom_range(0, 15));
                D_DATA_IN = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
